score_keeper: RTL and testbench

SCORE_KEEPER -- requirements
Module: score_keeper

---
 rtl/pong_pkg.sv | 39 +++
 rtl/score_digit.sv | 51 +++++
 rtl/score_keeper.sv | 177 +++++++++++++++++
 tb/tb_score_keeper.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// ============================================================================
// Module : pong_pkg
// Shared types, coordinate widths and seven-segment glyph table for Pong.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package pong_pkg;

   localparam int X_W = 11;
   localparam int Y_W = 10;

   typedef enum logic [1:0] {
      ST_SERVE = 2'd0,
      ST_PLAY  = 2'd1,
      ST_OVER  = 2'd2
   } state_e;

   localparam logic [1:0] WIN_NONE  = 2'b00;
   localparam logic [1:0] WIN_LEFT  = 2'b01;
   localparam logic [1:0] WIN_RIGHT = 2'b10;

   localparam int DIGIT_W = 20;
   localparam int DIGIT_H = 40;
   localparam int SEG_T   = 4;

   // Bit order {g,f,e,d,c,b,a}; entries 10..15 show hex glyphs A..F.
   localparam logic [6:0] SEG_TABLE [16] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
   };

   function automatic logic [3:0] sat_inc(input logic [3:0] v, input logic [3:0] lim);
      return (v >= lim) ? lim : v + 4'd1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/score_digit.sv
// ============================================================================
// Module : score_digit
// Combinational 20x40 seven-segment pixel test for one digit at a given origin.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module score_digit
   import pong_pkg::*;
(
   input  logic [3:0]     value_i,
   input  logic [X_W-1:0] org_x_i,
   input  logic [Y_W-1:0] org_y_i,
   input  logic [X_W-1:0] xPosition,
   input  logic [Y_W-1:0] yPosition,
   output logic           pixel_o
);

   logic [X_W-1:0] dx;
   logic [Y_W-1:0] dy;
   logic           in_box;
   logic           col_l;
   logic           col_r;
   logic           upper;
   logic [6:0]     seg_hit;

   always_comb begin
      dx     = xPosition - org_x_i;
      dy     = yPosition - org_y_i;
      // Offsets wrap when the scan is above/left of the origin, hence the explicit >= tests.
      in_box = (xPosition >= org_x_i) && (yPosition >= org_y_i) &&
               (dx < X_W'(DIGIT_W)) && (dy < Y_W'(DIGIT_H));
      col_l  = dx <  X_W'(SEG_T);
      col_r  = dx >= X_W'(DIGIT_W - SEG_T);
      upper  = dy <  Y_W'(DIGIT_H / 2);

      seg_hit[0] = dy < Y_W'(SEG_T);
      seg_hit[1] = col_r && upper;
      seg_hit[2] = col_r && !upper;
      seg_hit[3] = dy >= Y_W'(DIGIT_H - SEG_T);
      seg_hit[4] = col_l && !upper;
      seg_hit[5] = col_l && upper;
      seg_hit[6] = (dy >= Y_W'(DIGIT_H / 2 - SEG_T / 2)) &&
                   (dy <  Y_W'(DIGIT_H / 2 + SEG_T / 2));

      pixel_o = in_box && |(seg_hit & SEG_TABLE[value_i]);
   end

endmodule

`default_nettype wire

// File: rtl/score_keeper.sv
// ============================================================================
// Module : score_keeper
// Pong serve/play/over FSM with goal scoring; SCORE_DISPLAY_EN adds digit overlay.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module score_keeper
   import pong_pkg::*;
#(
   parameter int WIN_SCORE    = 9,
   parameter int LEFT_GOAL    = 10,
   parameter int RIGHT_GOAL   = 790,
   parameter int SERVE_DELAY  = 60,
   parameter int DIGIT_TOP    = 40,
   parameter int DIGIT_L_LEFT = 340,
   parameter int DIGIT_R_LEFT = 440
)(
   input  logic           Clock,
   input  logic           Reset,
   input  logic           tick,
   input  logic           restart,
   input  logic [X_W-1:0] ballLeft,
   input  logic [X_W-1:0] ballRight,
   input  logic [X_W-1:0] xPosition,
   input  logic [Y_W-1:0] yPosition,
   output logic [3:0]     scoreL,
   output logic [3:0]     scoreR,
   output logic           serveHold,
   output logic [1:0]     winner,
   output logic           drawScore
);

   localparam int CNT_W = (SERVE_DELAY < 2) ? 1 : $clog2(SERVE_DELAY + 1);

   localparam logic [CNT_W-1:0] c_serve_load = CNT_W'(SERVE_DELAY);
   localparam logic [3:0]       c_win        = 4'(WIN_SCORE);
   localparam logic [X_W-1:0]   c_left_goal  = X_W'(LEFT_GOAL);
   localparam logic [X_W-1:0]   c_right_goal = X_W'(RIGHT_GOAL);
   localparam logic [X_W-1:0]   c_org_l      = X_W'(DIGIT_L_LEFT);
   localparam logic [X_W-1:0]   c_org_r      = X_W'(DIGIT_R_LEFT);
   localparam logic [Y_W-1:0]   c_org_y      = Y_W'(DIGIT_TOP);

   state_e           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [3:0]       scoreL_q;
   logic [3:0]       scoreR_q;
   logic [1:0]       winner_q;
   logic             hold_q;

   logic             miss_l;
   logic             miss_r;
   logic [3:0]       incL;
   logic [3:0]       incR;

   assign miss_l = ballLeft  <= c_left_goal;
   assign miss_r = ballRight >= c_right_goal;
   assign incL   = sat_inc(scoreL_q, c_win);
   assign incR   = sat_inc(scoreR_q, c_win);

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         state_q  <= ST_SERVE;
         cnt_q    <= c_serve_load;
         scoreL_q <= 4'd0;
         scoreR_q <= 4'd0;
         winner_q <= WIN_NONE;
         hold_q   <= 1'b1;
      end else if (tick) begin
         case (state_q)
            ST_SERVE: begin
               if (cnt_q == '0) begin
                  state_q <= ST_PLAY;
                  hold_q  <= 1'b0;
               end else begin
                  cnt_q <= cnt_q - CNT_W'(1);
               end
            end

            ST_PLAY: begin
               // A simultaneous miss on both sides is a void rally: re-serve, no points.
               if (miss_l && miss_r) begin
                  state_q <= ST_SERVE;
                  cnt_q   <= c_serve_load;
                  hold_q  <= 1'b1;
               end else if (miss_l) begin
                  scoreR_q <= incR;
                  hold_q   <= 1'b1;
                  if (incR == c_win) begin
                     state_q  <= ST_OVER;
                     winner_q <= WIN_RIGHT;
                  end else begin
                     state_q <= ST_SERVE;
                     cnt_q   <= c_serve_load;
                  end
               end else if (miss_r) begin
                  scoreL_q <= incL;
                  hold_q   <= 1'b1;
                  if (incL == c_win) begin
                     state_q  <= ST_OVER;
                     winner_q <= WIN_LEFT;
                  end else begin
                     state_q <= ST_SERVE;
                     cnt_q   <= c_serve_load;
                  end
               end
            end

            ST_OVER: begin
               if (restart) begin
                  state_q  <= ST_SERVE;
                  cnt_q    <= c_serve_load;
                  scoreL_q <= 4'd0;
                  scoreR_q <= 4'd0;
                  winner_q <= WIN_NONE;
                  hold_q   <= 1'b1;
               end
            end

            default: begin
               state_q <= ST_SERVE;
               cnt_q   <= c_serve_load;
               hold_q  <= 1'b1;
            end
         endcase
      end
   end

   assign scoreL    = scoreL_q;
   assign scoreR    = scoreR_q;
   assign winner    = winner_q;
   assign serveHold = hold_q;

`ifdef SCORE_DISPLAY_EN
   logic pix_l;
   logic pix_r;
   logic draw_d;
   logic draw_q;

   score_digit u_digit_l (
      .value_i   (scoreL_q),
      .org_x_i   (c_org_l),
      .org_y_i   (c_org_y),
      .xPosition (xPosition),
      .yPosition (yPosition),
      .pixel_o   (pix_l)
   );

   score_digit u_digit_r (
      .value_i   (scoreR_q),
      .org_x_i   (c_org_r),
      .org_y_i   (c_org_y),
      .xPosition (xPosition),
      .yPosition (yPosition),
      .pixel_o   (pix_r)
   );

   assign draw_d = pix_l | pix_r;

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         draw_q <= 1'b0;
      end else begin
         draw_q <= draw_d;
      end
   end

   assign drawScore = draw_q;
`else
   logic unused_scan;
   assign unused_scan = ^{xPosition, yPosition, c_org_l, c_org_r, c_org_y};
   assign drawScore   = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_score_keeper.sv
// ============================================================================
// Module : tb_score_keeper
// Directed self-checking bench for score_keeper (default parameters).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_score_keeper;

   localparam int SD  = 60;
   localparam int WIN = 9;
   localparam int LG  = 10;
   localparam int RG  = 790;
   localparam int DT  = 40;
   localparam int DL  = 340;
   localparam int DR  = 440;

`ifdef SCORE_DISPLAY_EN
   localparam logic DISP = 1'b1;
`else
   localparam logic DISP = 1'b0;
`endif

   logic        Clock = 1'b0;
   logic        Reset;
   logic        tick;
   logic        restart;
   logic [10:0] ballLeft;
   logic [10:0] ballRight;
   logic [10:0] xPosition;
   logic [9:0]  yPosition;
   logic [3:0]  scoreL;
   logic [3:0]  scoreR;
   logic        serveHold;
   logic [1:0]  winner;
   logic        drawScore;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 Clock = ~Clock;

   score_keeper #(
      .WIN_SCORE    (WIN),
      .LEFT_GOAL    (LG),
      .RIGHT_GOAL   (RG),
      .SERVE_DELAY  (SD),
      .DIGIT_TOP    (DT),
      .DIGIT_L_LEFT (DL),
      .DIGIT_R_LEFT (DR)
   ) dut (
      .Clock     (Clock),
      .Reset     (Reset),
      .tick      (tick),
      .restart   (restart),
      .ballLeft  (ballLeft),
      .ballRight (ballRight),
      .xPosition (xPosition),
      .yPosition (yPosition),
      .scoreL    (scoreL),
      .scoreR    (scoreR),
      .serveHold (serveHold),
      .winner    (winner),
      .drawScore (drawScore)
   );

   task automatic tick_once();
      @(negedge Clock);
      tick = 1'b1;
      @(negedge Clock);
      tick = 1'b0;
   endtask

   task automatic serve();
      repeat (SD + 1) tick_once();
   endtask

   task automatic score_left();
      ballRight = 11'd795;
      tick_once();
      ballRight = 11'd400;
   endtask

   task automatic score_right();
      ballLeft = 11'd5;
      tick_once();
      ballLeft = 11'd400;
   endtask

   task automatic test_reset();
      Reset = 1'b0; tick = 1'b0; restart = 1'b0;
      ballLeft = 11'd400; ballRight = 11'd400; xPosition = 11'd0; yPosition = 10'd0;
      repeat (3) @(negedge Clock);
      n_cmp++; if (scoreL !== 4'd0) begin n_bad++; $display("FAIL reset_scoreL got %0d want 0", scoreL); end
      n_cmp++; if (scoreR !== 4'd0) begin n_bad++; $display("FAIL reset_scoreR got %0d want 0", scoreR); end
      n_cmp++; if (winner !== 2'b00) begin n_bad++; $display("FAIL reset_winner got %b want 00", winner); end
      n_cmp++; if (serveHold !== 1'b1) begin n_bad++; $display("FAIL reset_serveHold got %b want 1", serveHold); end
      n_cmp++; if (drawScore !== 1'b0) begin n_bad++; $display("FAIL reset_drawScore got %b want 0", drawScore); end
   endtask

   task automatic test_serve();
      @(negedge Clock);
      Reset = 1'b1;
      repeat (SD) tick_once();
      n_cmp++; if (serveHold !== 1'b1) begin n_bad++; $display("FAIL serve_tick60 got %b want 1", serveHold); end
      tick_once();
      n_cmp++; if (serveHold !== 1'b0) begin n_bad++; $display("FAIL serve_tick61 got %b want 0", serveHold); end
   endtask

   task automatic test_goal_right();
      ballLeft = 11'd5;
      repeat (3) @(negedge Clock);
      n_cmp++; if (scoreR !== 4'd0) begin n_bad++; $display("FAIL notick_scoreR got %0d want 0", scoreR); end
      n_cmp++; if (serveHold !== 1'b0) begin n_bad++; $display("FAIL notick_hold got %b want 0", serveHold); end
      tick_once();
      ballLeft = 11'd400;
      n_cmp++; if (scoreR !== 4'd1) begin n_bad++; $display("FAIL goal_scoreR got %0d want 1", scoreR); end
      n_cmp++; if (serveHold !== 1'b1) begin n_bad++; $display("FAIL goal_hold got %b want 1", serveHold); end
      restart = 1'b1;
      serve();
      restart = 1'b0;
      n_cmp++; if (scoreR !== 4'd1) begin n_bad++; $display("FAIL serve_restart_ign got %0d want 1", scoreR); end
      n_cmp++; if (serveHold !== 1'b0) begin n_bad++; $display("FAIL reserve_hold got %b want 0", serveHold); end
      ballLeft = 11'd11;
      tick_once();
      n_cmp++; if (scoreR !== 4'd1) begin n_bad++; $display("FAIL left11_scoreR got %0d want 1", scoreR); end
      n_cmp++; if (serveHold !== 1'b0) begin n_bad++; $display("FAIL left11_hold got %b want 0", serveHold); end
      ballLeft = 11'd10;
      tick_once();
      ballLeft = 11'd400;
      n_cmp++; if (scoreR !== 4'd2) begin n_bad++; $display("FAIL left10_scoreR got %0d want 2", scoreR); end
      serve();
   endtask

   task automatic test_both_goals();
      ballLeft = 11'd5; ballRight = 11'd795;
      tick_once();
      ballLeft = 11'd400; ballRight = 11'd400;
      n_cmp++; if (scoreL !== 4'd0) begin n_bad++; $display("FAIL both_scoreL got %0d want 0", scoreL); end
      n_cmp++; if (scoreR !== 4'd2) begin n_bad++; $display("FAIL both_scoreR got %0d want 2", scoreR); end
      n_cmp++; if (serveHold !== 1'b1) begin n_bad++; $display("FAIL both_hold got %b want 1", serveHold); end
      repeat (SD) tick_once();
      n_cmp++; if (serveHold !== 1'b1) begin n_bad++; $display("FAIL both_serve60 got %b want 1", serveHold); end
      tick_once();
      n_cmp++; if (serveHold !== 1'b0) begin n_bad++; $display("FAIL both_serve61 got %b want 0", serveHold); end
   endtask

   task automatic test_win_restart();
      restart = 1'b1;
      tick_once();
      restart = 1'b0;
      n_cmp++; if (scoreR !== 4'd2) begin n_bad++; $display("FAIL play_restart_ign got %0d want 2", scoreR); end
      n_cmp++; if (serveHold !== 1'b0) begin n_bad++; $display("FAIL play_restart_hold got %b want 0", serveHold); end
      for (int i = 0; i < 8; i++) begin
         ballRight = 11'd790;
         tick_once();
         ballRight = 11'd400;
         serve();
      end
      n_cmp++; if (scoreL !== 4'd8) begin n_bad++; $display("FAIL eight_scoreL got %0d want 8", scoreL); end
      n_cmp++; if (winner !== 2'b00) begin n_bad++; $display("FAIL eight_winner got %b want 00", winner); end
      score_left();
      n_cmp++; if (scoreL !== 4'd9) begin n_bad++; $display("FAIL win_scoreL got %0d want 9", scoreL); end
      n_cmp++; if (winner !== 2'b01) begin n_bad++; $display("FAIL win_winner got %b want 01", winner); end
      n_cmp++; if (serveHold !== 1'b1) begin n_bad++; $display("FAIL win_hold got %b want 1", serveHold); end
      ballLeft = 11'd5; ballRight = 11'd795;
      repeat (3) tick_once();
      ballLeft = 11'd400; ballRight = 11'd400;
      n_cmp++; if (scoreL !== 4'd9 || scoreR !== 4'd2) begin n_bad++; $display("FAIL over_hold_scores got %0d/%0d want 9/2", scoreL, scoreR); end
      n_cmp++; if (winner !== 2'b01) begin n_bad++; $display("FAIL over_winner got %b want 01", winner); end
      restart = 1'b1;
      repeat (2) @(negedge Clock);
      n_cmp++; if (scoreL !== 4'd9) begin n_bad++; $display("FAIL restart_notick got %0d want 9", scoreL); end
      tick_once();
      restart = 1'b0;
      n_cmp++; if (scoreL !== 4'd0 || scoreR !== 4'd0) begin n_bad++; $display("FAIL restart_scores got %0d/%0d want 0/0", scoreL, scoreR); end
      n_cmp++; if (winner !== 2'b00) begin n_bad++; $display("FAIL restart_winner got %b want 00", winner); end
      n_cmp++; if (serveHold !== 1'b1) begin n_bad++; $display("FAIL restart_hold got %b want 1", serveHold); end
      serve();
      n_cmp++; if (serveHold !== 1'b0) begin n_bad++; $display("FAIL restart_play got %b want 0", serveHold); end
   endtask

   task automatic test_draw();
      int   vx [8] = '{DL+10, DL+10, DR+10, DR+10, 0, DL-1, DL+19, DL+20};
      int   vy [8] = '{DT+1,  DT+20, DT+20, DT+1,  0, DT+1, DT+1,  DT+1};
      logic lit[8] = '{1'b1,  1'b1,  1'b0,  1'b1,  1'b0, 1'b0, 1'b1, 1'b0};
      logic exp_v;
      repeat (3) begin
         score_left();
         serve();
      end
      n_cmp++; if (scoreL !== 4'd3 || scoreR !== 4'd0) begin n_bad++; $display("FAIL draw_setup got %0d/%0d want 3/0", scoreL, scoreR); end
      for (int i = 0; i < 8; i++) begin
         xPosition = 11'(vx[i]);
         yPosition = 10'(vy[i]);
         @(negedge Clock);
         exp_v = DISP & lit[i];
         n_cmp++; if (drawScore !== exp_v) begin n_bad++; $display("FAIL draw_%0d at (%0d,%0d) got %b want %b", i, vx[i], vy[i], drawScore, exp_v); end
      end
      xPosition = 11'(DL + 10);
      yPosition = 10'(DT + 1);
      @(negedge Clock);
      xPosition = 11'd0;
      yPosition = 10'd0;
      #1;
      n_cmp++; if (drawScore !== DISP) begin n_bad++; $display("FAIL draw_latency got %b want %b", drawScore, DISP); end
      @(negedge Clock);
      n_cmp++; if (drawScore !== 1'b0) begin n_bad++; $display("FAIL draw_off got %b want 0", drawScore); end
   endtask

   task automatic test_async_reset();
      repeat (4) begin
         score_right();
         serve();
      end
      n_cmp++; if (scoreR !== 4'd4 || serveHold !== 1'b0) begin n_bad++; $display("FAIL arst_setup got R=%0d hold=%b want 4/0", scoreR, serveHold); end
      @(negedge Clock);
      #1 Reset = 1'b0;
      #1;
      n_cmp++; if (scoreL !== 4'd0 || scoreR !== 4'd0) begin n_bad++; $display("FAIL arst_scores got %0d/%0d want 0/0", scoreL, scoreR); end
      n_cmp++; if (serveHold !== 1'b1) begin n_bad++; $display("FAIL arst_hold got %b want 1", serveHold); end
      @(negedge Clock);
      Reset = 1'b1;
      repeat (SD) tick_once();
      n_cmp++; if (serveHold !== 1'b1) begin n_bad++; $display("FAIL arst_serve60 got %b want 1", serveHold); end
      tick_once();
      n_cmp++; if (serveHold !== 1'b0) begin n_bad++; $display("FAIL arst_serve61 got %b want 0", serveHold); end
   endtask

   initial begin
      test_reset();
      test_serve();
      test_goal_right();
      test_both_goals();
      test_win_restart();
      test_draw();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog expired after %0d compared", n_cmp);
      $fatal(1, "watchdog");
   end

endmodule

`default_nettype wire
